// File: rtl/gold_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gold_pkg
// Purpose  : Shared widths, FSM states and LFSR step for the Gold-code correlator.
// Revision : 1.0
// ============================================================================
package gold_pkg;

    localparam int LFSR_W   = 6;
    localparam int CODE_LEN = 63;
    localparam int CORR_W   = 7;

    localparam logic [LFSR_W-1:0] TAPS1_DEFAULT = 6'b100001;
    localparam logic [LFSR_W-1:0] TAPS2_DEFAULT = 6'b110011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        TRACK  = 2'd2
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                     input logic [LFSR_W-1:0] taps);
        return {s[LFSR_W-2:0], ^(s & taps)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gold_gen.sv
`default_nettype none
// ============================================================================
// Module   : gold_gen
// Purpose  : Two 6-bit m-sequence LFSRs whose MSBs are XORed into a Gold chip.
// Revision : 1.0
// ============================================================================
module gold_gen
    import gold_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TAPS1 = TAPS1_DEFAULT,
    parameter logic [LFSR_W-1:0] TAPS2 = TAPS2_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed1,
    input  logic [LFSR_W-1:0] seed2,
    input  logic              adv,
    output logic              chip
);

    logic [LFSR_W-1:0] r_s1;
    logic [LFSR_W-1:0] r_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else if (load) begin
            r_s1 <= seed1;
            r_s2 <= seed2;
        end else if (adv) begin
            r_s1 <= lfsr_step(r_s1, TAPS1);
            r_s2 <= lfsr_step(r_s2, TAPS2);
        end
    end

    assign chip = r_s1[LFSR_W-1] ^ r_s2[LFSR_W-1];

endmodule
`default_nettype wire

// File: rtl/gold_code_correlator.sv
`default_nettype none
// ============================================================================
// Module   : gold_code_correlator
// Purpose  : Despreads a chip stream against a local Gold code; searches code
//            phase by chip slipping, locks on a peak, emits one bit per window.
// Revision : 1.0
// ============================================================================
module gold_code_correlator
    import gold_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TAPS1    = TAPS1_DEFAULT,
    parameter logic [LFSR_W-1:0] TAPS2    = TAPS2_DEFAULT,
    parameter int                THRESH   = 48,
    parameter int                MISS_MAX = 3
) (
    input  logic                     clkin,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LFSR_W-1:0]        code1,
    input  logic [LFSR_W-1:0]        code2,
    input  logic                     chip_valid,
    input  logic                     chip_in,
    output logic                     ready,
    output logic                     locked,
    output logic                     bit_valid,
    output logic                     bit_out,
    output logic signed [CORR_W-1:0] corr_out,
    output logic [LFSR_W-1:0]        phase,
    output logic                     seed_err,
    output logic                     search_wrap
);

    localparam int c_WIDE_W = CORR_W + 1;
    localparam int c_MISS_W = $clog2(MISS_MAX + 1);

    state_t                r_state, w_state_nxt;
    logic [LFSR_W-1:0]     r_win_cnt, r_phase, w_phase_nxt;
    logic [CORR_W-1:0]     r_match, w_matches;
    logic [c_MISS_W-1:0]   r_miss, w_miss_nxt;
    logic                  r_slip_hold, w_hold_nxt;
    logic                  r_bit_valid, r_bit_out, r_seed_err, r_wrap;
    logic [CORR_W-1:0]     r_corr;
    logic                  w_gold, w_accept, w_win_end, w_load, w_seed_err, w_wrap, w_peak;
    logic [c_WIDE_W-1:0]   w_corr_wide, w_abs;

    gold_gen #(
        .TAPS1 (TAPS1),
        .TAPS2 (TAPS2)
    ) u_gen (
        .clk   (clkin),
        .rst   (rst),
        .load  (w_load),
        .seed1 (code1),
        .seed2 (code2),
        .adv   (w_accept && !r_slip_hold),
        .chip  (w_gold)
    );

    // start takes priority: a chip arriving alongside it is dropped
    assign w_accept    = chip_valid && !start && (r_state != IDLE);
    assign w_win_end   = w_accept && (r_win_cnt == LFSR_W'(CODE_LEN - 1));
    assign w_matches   = r_match + CORR_W'(chip_in == w_gold);
    assign w_corr_wide = {w_matches, 1'b0} - c_WIDE_W'(CODE_LEN);
    assign w_abs       = w_corr_wide[c_WIDE_W-1] ? -w_corr_wide : w_corr_wide;
    assign w_peak      = (w_abs >= c_WIDE_W'(THRESH));

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_miss_nxt  = r_miss;
        w_hold_nxt  = r_slip_hold;
        w_load      = 1'b0;
        w_seed_err  = 1'b0;
        w_wrap      = 1'b0;
        if (start) begin
            if ((code1 == '0) || (code2 == '0)) begin
                w_seed_err  = 1'b1;
                w_state_nxt = IDLE;
            end else begin
                w_load      = 1'b1;
                w_state_nxt = SEARCH;
                w_phase_nxt = '0;
                w_miss_nxt  = '0;
                w_hold_nxt  = 1'b0;
            end
        end else if (w_accept) begin
            w_hold_nxt = 1'b0;
            if (w_win_end) begin
                case (r_state)
                    SEARCH: begin
                        if (w_peak) begin
                            w_state_nxt = TRACK;
                            w_miss_nxt  = '0;
                        end else begin
                            // hold the local code for one chip to try the next phase
                            w_hold_nxt = 1'b1;
                            if (r_phase == LFSR_W'(CODE_LEN - 1)) begin
                                w_phase_nxt = '0;
                                w_wrap      = 1'b1;
                            end else begin
                                w_phase_nxt = r_phase + 1'b1;
                            end
                        end
                    end
                    TRACK: begin
                        if (w_peak) begin
                            w_miss_nxt = '0;
                        end else if (r_miss == c_MISS_W'(MISS_MAX - 1)) begin
                            w_state_nxt = SEARCH;
                            w_miss_nxt  = '0;
                            w_hold_nxt  = 1'b1;
                        end else begin
                            w_miss_nxt = r_miss + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_win_cnt   <= '0;
            r_match     <= '0;
            r_phase     <= '0;
            r_miss      <= '0;
            r_slip_hold <= 1'b0;
            r_bit_valid <= 1'b0;
            r_bit_out   <= 1'b0;
            r_corr      <= '0;
            r_seed_err  <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_miss      <= w_miss_nxt;
            r_slip_hold <= w_hold_nxt;
            r_bit_valid <= w_win_end;
            r_seed_err  <= w_seed_err;
            r_wrap      <= w_wrap;
            if (w_load) begin
                r_win_cnt <= '0;
                r_match   <= '0;
            end else if (w_win_end) begin
                r_win_cnt <= '0;
                r_match   <= '0;
                r_corr    <= w_corr_wide[CORR_W-1:0];
                r_bit_out <= w_corr_wide[c_WIDE_W-1];
            end else if (w_accept) begin
                r_win_cnt <= r_win_cnt + 1'b1;
                r_match   <= w_matches;
            end
        end
    end

    assign ready       = (r_state == IDLE);
    assign locked      = (r_state == TRACK);
    assign bit_valid   = r_bit_valid;
    assign bit_out     = r_bit_out;
    assign corr_out    = r_corr;
    assign phase       = r_phase;
    assign seed_err    = r_seed_err;
    assign search_wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_gold_code_correlator.sv
`default_nettype none
// ============================================================================
// Module   : tb_gold_code_correlator
// Purpose  : Directed + randomized bench with a window-level correlation model.
// Revision : 1.0
// ============================================================================
module tb_gold_code_correlator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] code1 = '0;
    logic [5:0] code2 = '0;
    logic       chip_valid = 1'b0;
    logic       chip_in = 1'b0;
    logic       ready, locked, bit_valid, bit_out, seed_err, search_wrap;
    logic [6:0] corr_out;
    logic [5:0] phase;

    int checks   = 0;
    int failures = 0;

    // reference code table and spreader/receiver model state
    bit g [0:62];
    int m_mode;     // 0 idle, 1 search, 2 track
    int m_lidx, m_phase, m_miss, m_match, m_wcnt, m_corr, tt;
    bit m_held, m_bv, m_wrap;

    gold_code_correlator #(
        .THRESH   (48),
        .MISS_MAX (3)
    ) dut (
        .clkin       (clk),
        .rst         (rst),
        .start       (start),
        .code1       (code1),
        .code2       (code2),
        .chip_valid  (chip_valid),
        .chip_in     (chip_in),
        .ready       (ready),
        .locked      (locked),
        .bit_valid   (bit_valid),
        .bit_out     (bit_out),
        .corr_out    (corr_out),
        .phase       (phase),
        .seed_err    (seed_err),
        .search_wrap (search_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_lidx = 0; m_phase = 0; m_miss = 0; m_match = 0; m_wcnt = 0;
        m_held = 0; m_bv = 0; m_wrap = 0; tt = 0;
    endtask

    task automatic model_step(input bit c);
        bit peak;
        m_bv = 0;
        m_wrap = 0;
        if (m_mode != 0) begin
            if (c == g[m_lidx]) m_match++;
            if (m_held) m_held = 0;
            else m_lidx = (m_lidx + 1) % 63;
            m_wcnt++;
            if (m_wcnt == 63) begin
                m_corr = 2 * m_match - 63;
                m_bv = 1;
                peak = (m_corr >= 48) || (m_corr <= -48);
                if (m_mode == 1) begin
                    if (peak) begin
                        m_mode = 2; m_miss = 0;
                    end else begin
                        m_held = 1;
                        if (m_phase == 62) begin m_phase = 0; m_wrap = 1; end
                        else m_phase++;
                    end
                end else begin
                    if (peak) m_miss = 0;
                    else begin
                        m_miss++;
                        if (m_miss == 3) begin m_mode = 1; m_miss = 0; m_held = 1; end
                    end
                end
                m_match = 0;
                m_wcnt = 0;
            end
        end
    endtask

    task automatic send(input bit c);
        logic [6:0] e7;
        chip_valid = 1'b1;
        chip_in = c;
        @(posedge clk);
        #1;
        model_step(c);
        chk("bit_valid", bit_valid, m_bv);
        chk("locked", locked, m_mode == 2);
        chk("ready", ready, m_mode == 0);
        chk("phase", phase, m_phase[5:0]);
        chk("search_wrap", search_wrap, m_wrap);
        if (m_bv) begin
            e7 = m_corr[6:0];
            chk("corr_out", corr_out, e7);
            chk("bit_out", bit_out, m_corr < 0);
        end
    endtask

    // one receiver window of the spread stream, delayed d chips, first errs chips inverted
    task automatic send_window(input int d, input bit data, input int errs);
        bit c;
        for (int i = 0; i < 63; i++) begin
            c = g[(((tt - d) % 63) + 63) % 63] ^ data;
            if (i < errs) c = ~c;
            send(c);
            tt++;
        end
    endtask

    task automatic do_start(input logic [5:0] c1, input logic [5:0] c2);
        bit bad;
        bad = (c1 == 0) || (c2 == 0);
        chip_valid = 1'b0;
        start = 1'b1;
        code1 = c1;
        code2 = c2;
        @(posedge clk);
        #1;
        start = 1'b0;
        model_clear();
        m_mode = bad ? 0 : 1;
        chk("seed_err", seed_err, bad);
        chk("start_ready", ready, bad);
        chk("start_locked", locked, 1'b0);
        chk("start_phase", phase, 6'd0);
    endtask

    initial begin
        logic [5:0] s1, s2;
        int d;
        s1 = 6'b000001;
        s2 = 6'b000011;
        for (int k = 0; k < 63; k++) begin
            g[k] = s1[5] ^ s2[5];
            s1 = {s1[4:0], ^(s1 & 6'b100001)};
            s2 = {s2[4:0], ^(s2 & 6'b110011)};
        end
        m_mode = 0;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", ready, 1'b1);
        chk("rst_locked", locked, 1'b0);
        chk("rst_bit_valid", bit_valid, 1'b0);
        chk("rst_corr", corr_out, 7'd0);
        chk("rst_bit_out", bit_out, 1'b0);
        chk("rst_phase", phase, 6'd0);
        chk("rst_seed_err", seed_err, 1'b0);
        chk("rst_wrap", search_wrap, 1'b0);

        // zero seed rejected; chips ignored while idle
        do_start(6'd0, 6'd3);
        for (int i = 0; i < 200; i++) begin
            send(1'($urandom_range(0, 1)));
            if (i == 0) chk("seed_err_pulse", seed_err, 1'b0);
        end
        chk("t1_ready", ready, 1'b1);

        // aligned stream locks in the first window
        do_start(6'd1, 6'd3);
        send_window(0, 1'b0, 0);
        chk("t2_corr", corr_out, 7'd63);
        chk("t2_locked", locked, 1'b1);
        chk("t2_phase", phase, 6'd0);

        // data bits while tracking
        send_window(0, 1'b1, 0);
        chk("t4_corr_a", corr_out, 7'h41);
        chk("t4_bit_a", bit_out, 1'b1);
        send_window(0, 1'b0, 0);
        chk("t4_corr_b", corr_out, 7'd63);
        send_window(0, 1'b1, 0);
        send_window(0, 1'b1, 0);
        chk("t4_bit_d", bit_out, 1'b1);

        // chip errors keep lock; flat zero stream drops it on the third miss
        send_window(0, 1'b0, 7);
        chk("t5_corr49", corr_out, 7'd49);
        chk("t5_locked", locked, 1'b1);
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 63; i++) begin send(1'b0); tt++; end
            chk("t5_drop", locked, w < 2);
        end

        // stream delayed 5 chips: five slips then lock
        do_start(6'd1, 6'd3);
        for (int w = 0; w < 5; w++) send_window(5, 1'b0, 0);
        chk("t3_unlocked", locked, 1'b0);
        send_window(5, 1'b0, 0);
        chk("t3_locked", locked, 1'b1);
        chk("t3_phase", phase, 6'd5);
        send_window(5, 1'b0, 0);
        chk("t3_corr", corr_out, 7'd63);

        // random delay, random data and error counts
        d = int'($urandom_range(1, 10));
        do_start(6'd1, 6'd3);
        for (int w = 0; w < d + 1; w++) send_window(d, 1'b0, 0);
        for (int w = 0; w < 8; w++)
            send_window(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        chk("rnd_locked", locked, 1'b1);
        chk("rnd_phase", phase, d[5:0]);

        // noise: full phase sweep wraps
        do_start(6'd1, 6'd3);
        for (int i = 0; i < 63 * 63; i++) send(1'($urandom_range(0, 1)));
        chk("wrap_phase", phase, m_phase[5:0]);

        // asynchronous reset mid-window
        do_start(6'd1, 6'd3);
        send_window(0, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin send(g[tt % 63]); tt++; end
        #2;
        rst = 1'b1;
        chip_valid = 1'b0;
        #1;
        m_mode = 0;
        model_clear();
        chk("t6_rst_ready", ready, 1'b1);
        chk("t6_rst_locked", locked, 1'b0);
        chk("t6_rst_corr", corr_out, 7'd0);
        chk("t6_rst_bv", bit_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // restart mid-track
        do_start(6'd1, 6'd3);
        send_window(0, 1'b0, 0);
        for (int i = 0; i < 30; i++) begin send(g[tt % 63]); tt++; end
        chk("t6_pre_locked", locked, 1'b1);
        do_start(6'd1, 6'd3);
        chk("t6_search", locked, 1'b0);
        send_window(0, 1'b0, 0);
        chk("t6_corr", corr_out, 7'd63);
        chk("t6_locked", locked, 1'b1);

        chip_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
